button_scan_controller: RTL

Time-multiplexed debounce scheduler for all Nexys 4 DDR push-buttons of the timer. A single evaluation datapath (sampler, comparator and counter update) is shared round-robin across N_BTN buttons, one button serviced per DIV_CLK tick. Produces stable levels, one-CLK press/release pulses and per-button toggle states, which feed the timer control logic in place of per-button debouncer instances.

---
 rtl/button_scan_controller_pkg.sv | 13 +
 rtl/button_scan_controller_if.sv | 25 ++
 rtl/button_scan_controller_sync_edge.sv | 17 +
 rtl/button_scan_controller.sv | 112 +++++++++++
 4 files changed

// File: rtl/button_scan_controller_pkg.sv
// Shared definitions for the button scan controller: FSM encoding and default sizing.
package button_scan_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int DEF_N_BTN        = 5;
    localparam int DEF_STABLE_TICKS = 4;

endpackage

// File: rtl/button_scan_controller_if.sv
// Button bus between the timer control logic (master) and the scan controller (slave).
interface button_scan_controller_if #(
    parameter int N_BTN = 5,
    parameter int IDX_W = 3
);
    logic             DIV_CLK;
    logic             ENABLE;
    logic [N_BTN-1:0] IN;
    logic [N_BTN-1:0] STABLE;
    logic [N_BTN-1:0] PRESS;
    logic [N_BTN-1:0] RELEASE;
    logic [N_BTN-1:0] TOGGLE;
    logic [IDX_W-1:0] SCAN_IDX;
    logic             OVERRUN;

    modport master (
        output DIV_CLK, ENABLE, IN,
        input  STABLE, PRESS, RELEASE, TOGGLE, SCAN_IDX, OVERRUN
    );

    modport slave (
        input  DIV_CLK, ENABLE, IN,
        output STABLE, PRESS, RELEASE, TOGGLE, SCAN_IDX, OVERRUN
    );
endinterface

// File: rtl/button_scan_controller_sync_edge.sv
// Two-flop synchroniser for a slow level, plus a one-clock pulse on its rising edge.
module button_scan_controller_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    // sh[1] is the synchronised level, sh[2] its previous value
    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (rst) sh <= '0;
        else     sh <= {sh[1:0], d};
    end

    assign rise = sh[1] & ~sh[2];
endmodule

// File: rtl/button_scan_controller.sv
// Round-robin debounce scheduler: one shared sample/compare/count datapath serves all buttons.
module button_scan_controller
    import button_scan_controller_pkg::*;
#(
    parameter int N_BTN        = DEF_N_BTN,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int CNT_W        = 4,
    parameter int IDX_W        = 3
) (
    input logic CLK,
    input logic RESET,
    button_scan_controller_if.slave bus
);
    logic [N_BTN-1:0]            in_m, in_s;
    logic                        tick, tick_en;
    state_t                      state;
    logic                        pending, overrun_q;
    logic [N_BTN-1:0][CNT_W-1:0] cnt;
    logic [N_BTN-1:0]            stable_q, press_q, release_q, toggle_q;
    logic [IDX_W-1:0]            idx;
    logic                        b_w, s_w;
    logic [CNT_W-1:0]            c_w;

    button_scan_controller_sync_edge u_div_sync (
        .clk  (CLK),
        .rst  (RESET),
        .d    (bus.DIV_CLK),
        .rise (tick)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_m <= '0;
            in_s <= '0;
        end else begin
            in_m <= bus.IN;
            in_s <= in_m;
        end
    end

    assign tick_en = tick & bus.ENABLE;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            pending   <= 1'b0;
            overrun_q <= 1'b0;
            cnt       <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            toggle_q  <= '0;
            idx       <= '0;
            b_w       <= 1'b0;
            s_w       <= 1'b0;
            c_w       <= '0;
        end else begin
            press_q   <= '0;
            release_q <= '0;
            case (state)
                IDLE: begin
                    // a fresh tick colliding with a queued one has nowhere to go
                    if (bus.ENABLE && (tick || pending)) begin
                        state   <= EVAL;
                        pending <= 1'b0;
                        if (tick && pending) overrun_q <= 1'b1;
                    end
                end
                EVAL: begin
                    b_w   <= in_s[idx];
                    s_w   <= stable_q[idx];
                    c_w   <= cnt[idx];
                    state <= COMMIT;
                    if (tick_en) begin
                        if (pending) overrun_q <= 1'b1;
                        pending <= 1'b1;
                    end
                end
                COMMIT: begin
                    if (b_w == s_w) begin
                        cnt[idx] <= '0;
                    end else if (c_w < CNT_W'(STABLE_TICKS - 1)) begin
                        cnt[idx] <= c_w + 1'b1;
                    end else begin
                        cnt[idx]      <= '0;
                        stable_q[idx] <= b_w;
                        if (b_w) begin
                            press_q[idx]  <= 1'b1;
                            toggle_q[idx] <= ~toggle_q[idx];
                        end else begin
                            release_q[idx] <= 1'b1;
                        end
                    end
                    idx   <= (idx == IDX_W'(N_BTN - 1)) ? '0 : idx + 1'b1;
                    state <= IDLE;
                    if (tick_en) begin
                        if (pending) overrun_q <= 1'b1;
                        pending <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.STABLE   = stable_q;
    assign bus.PRESS    = press_q;
    assign bus.RELEASE  = release_q;
    assign bus.TOGGLE   = toggle_q;
    assign bus.SCAN_IDX = idx;
    assign bus.OVERRUN  = overrun_q;
endmodule
